r0_writeback: RTL

- Return path for register r0: takes the two result bytes produced downstream of the r0 operand multiplexer and writes one of them, or their sum, back into r0.
- Mode select uses the same 2-bit state encoding as the operand path.
- Handshake is en in, ready out. The block owns the r0 storage register and a carry flag, and sits between the ALU result bus and the register file.

---
 rtl/r0_pkg.sv | 16 +
 rtl/r0_wb_datapath.sv | 47 ++++
 rtl/r0_writeback.sv | 111 +++++++++++
 3 files changed

// File: rtl/r0_pkg.sv
// r0 writeback shared definitions: write-mode constants (also used by the
// r0 operand multiplexer) and writeback FSM state encodings.
package r0_pkg;

    localparam logic [1:0] R0_MODE_NOP = 2'd0;
    localparam logic [1:0] R0_MODE_V1  = 2'd1;
    localparam logic [1:0] R0_MODE_V2  = 2'd2;
    localparam logic [1:0] R0_MODE_SUM = 2'd3;

    typedef enum logic [1:0] {
        R0_WB_IDLE = 2'd0,
        R0_WB_EXEC = 2'd1,
        R0_WB_DONE = 2'd2
    } r0_wb_state_t;

endpackage

// File: rtl/r0_wb_datapath.sv
// r0 writeback next-value logic (combinational).
// Ports: mode, value1, value2, r0_cur, carry_cur in; r0_next, carry_next out.
// Build option R0_SATURATE_EN: mode 3 clamps r0 to all ones on overflow.
module r0_wb_datapath
    import r0_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    input  logic [WIDTH-1:0] r0_cur,
    input  logic             carry_cur,
    output logic [WIDTH-1:0] r0_next,
    output logic             carry_next
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, value1} + {1'b0, value2};

    always_comb begin
        r0_next    = r0_cur;
        carry_next = carry_cur;
        unique case (mode)
            R0_MODE_NOP: begin
                r0_next    = r0_cur;
                carry_next = carry_cur;
            end
            R0_MODE_V1: r0_next = value1;
            R0_MODE_V2: r0_next = value2;
            R0_MODE_SUM: begin
                carry_next = sum[WIDTH];
`ifdef R0_SATURATE_EN
                r0_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                r0_next = sum[WIDTH-1:0];
`endif
            end
            default: begin
                r0_next    = r0_cur;
                carry_next = carry_cur;
            end
        endcase
    end

endmodule

// File: rtl/r0_writeback.sv
// r0 writeback: captures a request in IDLE, writes r0 in EXEC, pulses ready.
// Ports: clk, rst_n, en, state[1:0], value1, value2 in; r0, carry, busy, ready out.
// Build option R0_SATURATE_EN (see r0_wb_datapath) saturates mode-3 writes.
module r0_writeback
    import r0_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] R0_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       state,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    output logic [WIDTH-1:0] r0,
    output logic             carry,
    output logic             busy,
    output logic             ready
);

    r0_wb_state_t     fsm_q;
    r0_wb_state_t     fsm_d;
    logic             capture;
    logic             write;
    logic             ready_d;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] v1_q;
    logic [WIDTH-1:0] v2_q;
    logic [WIDTH-1:0] r0_next;
    logic             carry_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= R0_WB_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Unused encoding falls back to IDLE without writing.
    always_comb begin
        fsm_d   = R0_WB_IDLE;
        capture = 1'b0;
        write   = 1'b0;
        ready_d = 1'b0;
        unique case (fsm_q)
            R0_WB_IDLE: begin
                if (en) begin
                    capture = 1'b1;
                    fsm_d   = R0_WB_EXEC;
                end else begin
                    fsm_d = R0_WB_IDLE;
                end
            end
            R0_WB_EXEC: begin
                write   = 1'b1;
                ready_d = 1'b1;
                fsm_d   = R0_WB_DONE;
            end
            R0_WB_DONE: begin
                fsm_d = R0_WB_IDLE;
            end
            default: begin
                fsm_d = R0_WB_IDLE;
            end
        endcase
    end

    assign busy = (fsm_q != R0_WB_IDLE);

    r0_wb_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .mode      (mode_q),
        .value1    (v1_q),
        .value2    (v2_q),
        .r0_cur    (r0),
        .carry_cur (carry),
        .r0_next   (r0_next),
        .carry_next(carry_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= R0_MODE_NOP;
            v1_q   <= '0;
            v2_q   <= '0;
        end else if (capture) begin
            mode_q <= state;
            v1_q   <= value1;
            v2_q   <= value2;
        end
    end

    // ready rises together with the new r0 value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0    <= R0_RESET;
            carry <= 1'b0;
            ready <= 1'b0;
        end else begin
            ready <= ready_d;
            if (write) begin
                r0    <= r0_next;
                carry <= carry_next;
            end
        end
    end

endmodule
